// File: rtl/serial_a_paralelo_pkg.sv
// serial_a_paralelo_pkg: shared PCIe physical-layer constants and the receiver alignment state encoding.
package serial_a_paralelo_pkg;
    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_e;
    localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;
    localparam int         LOCK_COUNT_DEF = 4;
    localparam logic [7:0] TX_IDLE        = COM_SYMBOL_DEF;
endpackage

// File: rtl/serial_a_paralelo_com_detect.sv
// com_detect: flags when the incoming shift-register value equals the comma symbol.
module com_detect
    import serial_a_paralelo_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF
) (
    input  logic [7:0] sr_next_i,
    output logic       is_com_o
);
    assign is_com_o = (sr_next_i == COM_SYMBOL);
endmodule

// File: rtl/serial_a_paralelo.sv
// serial_a_paralelo: aligns an MSB-first serial stream on comma bytes and emits the decoded data bytes.
module serial_a_paralelo
    import serial_a_paralelo_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF,
    parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       byte_strobe,
    output logic       active
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    typedef logic [CW-1:0] cnt_t;

    state_e     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    cnt_t       com_cnt_q, com_cnt_d, com_inc;
    logic [7:0] out_q, out_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       active_q, active_d;
    logic       is_com, boundary;

    assign sr_d     = {sr_q[6:0], in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign com_inc  = com_cnt_q + cnt_t'(1);

    com_detect #(.COM_SYMBOL(COM_SYMBOL)) u_com_detect (
        .sr_next_i(sr_d),
        .is_com_o (is_com)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        out_d     = out_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        active_d  = active_q;
        case (state_q)
            SEARCH: begin
                bit_cnt_d = '0;
                if (is_com) begin
                    state_d   = ALIGN;
                    com_cnt_d = cnt_t'(1);
                end
            end
            ALIGN: begin
                // A failed boundary drops back to SEARCH without re-testing this cycle's window
                if (boundary && is_com) begin
                    com_cnt_d = com_inc;
                    if (com_inc == cnt_t'(LOCK_COUNT)) begin
                        state_d  = LOCKED;
                        active_d = 1'b1;
                    end
                end else if (boundary) begin
                    state_d   = SEARCH;
                    com_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    valid_d  = !is_com;
                    out_d    = is_com ? out_q : sr_d;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;
endmodule

// File: tb/tb_serial_a_paralelo.sv
// tb_serial_a_paralelo: directed scenarios for comma alignment, lock, data decode, reset and bit slip.
module tb_serial_a_paralelo;
    import serial_a_paralelo_pkg::*;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b1;
    logic       ser_in = 1'b0;
    logic [7:0] out;
    logic       out_valid, byte_strobe, active;
    int         total = 0;
    int         bad   = 0;

    serial_a_paralelo dut (
        .clk32f     (clk32f),
        .reset      (reset),
        .in         (ser_in),
        .out        (out),
        .out_valid  (out_valid),
        .byte_strobe(byte_strobe),
        .active     (active)
    );

    always #5 clk32f = ~clk32f;

    task automatic send_bit(input logic b);
        ser_in = b;
        @(posedge clk32f);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    // Stands in for the paralelo_a_serial transmitter: idle sends the comma byte
    task automatic tx_byte(input logic in_valid, input logic [7:0] data);
        send_byte(in_valid ? data : TX_IDLE);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({out, out_valid, byte_strobe, active} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b exp=00/0/0/0", out, out_valid, byte_strobe, active);
        end
        @(posedge clk32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lock();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL lock_early got=%b exp=0", active); end
        send_bits(8'hBC, 7);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL lock_before_lsb got=%b exp=0", active); end
        send_bit(1'b0);
        total++;
        if (active !== 1'b1) begin bad++; $display("FAIL lock_active got=%b exp=1", active); end
        total++;
        if (out_valid !== 1'b0 || byte_strobe !== 1'b0) begin
            bad++;
            $display("FAIL lock_no_valid got=%b/%b exp=0/0", out_valid, byte_strobe);
        end
    endtask

    task automatic test_data();
        int held;
        send_bits(8'h5A, 7);
        total++;
        if (out_valid !== 1'b0 || byte_strobe !== 1'b0) begin
            bad++;
            $display("FAIL data_pre got=%b/%b exp=0/0", out_valid, byte_strobe);
        end
        send_bit(1'b0);
        total++;
        if (out !== 8'h5A || out_valid !== 1'b1 || byte_strobe !== 1'b1) begin
            bad++;
            $display("FAIL data_5a got=%h/%b/%b exp=5a/1/1", out, out_valid, byte_strobe);
        end
        held = 0;
        for (int i = 7; i > 0; i--) begin
            send_bit(TX_IDLE[i]);
            if (out_valid === 1'b1 && byte_strobe === 1'b0 && out === 8'h5A) held++;
        end
        total++;
        if (held !== 7) begin bad++; $display("FAIL data_hold got=%0d exp=7", held); end
        send_bit(TX_IDLE[0]);
        total++;
        if (out !== 8'h5A || out_valid !== 1'b0 || byte_strobe !== 1'b1) begin
            bad++;
            $display("FAIL data_idle got=%h/%b/%b exp=5a/0/1", out, out_valid, byte_strobe);
        end
        send_bit(1'b1);
        total++;
        if (byte_strobe !== 1'b0) begin bad++; $display("FAIL strobe_width got=%b exp=0", byte_strobe); end
        send_bits(8'hBC << 1, 7);
    endtask

    task automatic test_misalign();
        pulse_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
        total++;
        if (active !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_search got=%b/%b exp=0/0", active, out_valid);
        end
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL misalign_early got=%b exp=0", active); end
        send_byte(8'hBC);
        total++;
        if (active !== 1'b1) begin bad++; $display("FAIL misalign_relock got=%b exp=1", active); end
    endtask

    task automatic test_loopback();
        logic [7:0] pat [3] = '{8'h01, 8'hFF, 8'h80};
        tx_byte(1'b0, 8'h00);
        tx_byte(1'b0, 8'h00);
        foreach (pat[j]) begin
            tx_byte(1'b1, pat[j]);
            total++;
            if (out !== pat[j] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL loopback_%0d got=%h/%b exp=%h/1", j, out, out_valid, pat[j]);
            end
        end
        tx_byte(1'b0, 8'h00);
        total++;
        if (out !== 8'h80 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL loopback_idle got=%h/%b exp=80/0", out, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        send_bits(8'h77, 3);
        reset = 1'b1;
        #1;
        total++;
        if ({out, out_valid, byte_strobe, active} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h/%b/%b/%b exp=00/0/0/0", out, out_valid, byte_strobe, active);
        end
        @(posedge clk32f);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL midreset_early got=%b exp=0", active); end
        send_byte(8'hBC);
        total++;
        if (active !== 1'b1) begin bad++; $display("FAIL midreset_relock got=%b exp=1", active); end
    endtask

    task automatic test_slip();
        pulse_reset();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_bit(1'b1); send_bit(1'b0); send_bits(8'hBC << 3, 5);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL slip_early got=%b exp=0", active); end
        send_byte(8'hBC);
        total++;
        if (active !== 1'b1) begin bad++; $display("FAIL slip_lock got=%b exp=1", active); end
        send_byte(8'h3C);
        total++;
        if (out !== 8'h3C || out_valid !== 1'b1 || byte_strobe !== 1'b1) begin
            bad++;
            $display("FAIL slip_data got=%h/%b/%b exp=3c/1/1", out, out_valid, byte_strobe);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data();
        test_misalign();
        test_loopback();
        test_reset_mid();
        test_slip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_a_paralelo.md
SERIAL_A_PARALELO -- requirements
Module: serial_a_paralelo

Interface
REQ-001 Parameter: COM_SYMBOL, default 8'hBC; the idle/comma byte the transmitter sends when it has no valid data.
REQ-002 Parameter: LOCK_COUNT, default 4; number of consecutive aligned COM bytes required to declare lock.
REQ-003 Port: clk32f  input  1  serial bit clock; the block's only clock; all logic samples on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in  input  1  serial bit stream, one bit per clk32f cycle, byte MSB first.
REQ-006 Port: out  output  8  last completed non-COM byte; held stable between byte boundaries.
REQ-007 Port: out_valid  output  1  high while out holds a data byte from the most recent byte slot.
REQ-008 Port: byte_strobe  output  1  one-cycle pulse on each completed byte boundary once locked.
REQ-009 Port: active  output  1  high once byte alignment is locked.

Function
REQ-010 The block SHALL keep an 8-bit shift register sr with sr_next = {sr[6:0], in}, updated every cycle in all states.
REQ-011 The block SHALL implement three states: SEARCH, ALIGN and LOCKED.
REQ-012 SEARCH: every cycle, if sr_next == COM_SYMBOL, the block SHALL go to ALIGN with bit_cnt = 0 and com_cnt = 1; otherwise it SHALL stay in SEARCH.
REQ-013 The 3-bit bit_cnt SHALL increment by 1 each cycle in ALIGN and LOCKED and wrap from 7 to 0; a byte boundary is the cycle in which bit_cnt == 7.
REQ-014 ALIGN, byte boundary, sr_next == COM_SYMBOL: com_cnt SHALL increment; if the new value equals LOCK_COUNT, the block SHALL go to LOCKED and set active = 1 at the same edge.
REQ-015 ALIGN, byte boundary, sr_next != COM_SYMBOL: the block SHALL return to SEARCH and clear com_cnt; that same cycle SHALL NOT be re-tested as a SEARCH match.
REQ-016 ALIGN, non-boundary cycles: the state and com_cnt SHALL be unchanged.
REQ-017 LOCKED, byte boundary: byte_strobe SHALL pulse high for exactly that cycle.
REQ-018 LOCKED, byte boundary, sr_next != COM_SYMBOL: out SHALL take sr_next and out_valid SHALL be 1.
REQ-019 LOCKED, byte boundary, sr_next == COM_SYMBOL: out_valid SHALL be 0 and out SHALL hold its previous value.
REQ-020 Latency: out and out_valid SHALL update on the same clk32f edge that samples the byte's last (LSB) bit, so they are visible one cycle after that bit is presented.
REQ-021 LOCKED SHALL be sticky; only reset leaves it. Data bytes equal to COM_SYMBOL are indistinguishable from idle by design.
REQ-022 com_cnt SHALL be wide enough for LOCK_COUNT and SHALL never wrap.
REQ-023 In SEARCH and ALIGN, out_valid, byte_strobe and active SHALL be 0.

Reset
REQ-024 While reset is high, the block SHALL asynchronously force: state = SEARCH, sr = 0, bit_cnt = 0, com_cnt = 0, out = 8'h00, out_valid = 0, byte_strobe = 0, active = 0.
REQ-025 Reset asserted mid-byte or while LOCKED SHALL discard all partial and lock state; after reset is released, alignment SHALL restart from SEARCH on the first rising edge.

Structure
REQ-026 The state encoding (SEARCH, ALIGN, LOCKED) and the defaults for COM_SYMBOL and LOCK_COUNT SHALL live in the shared PCIe physical-layer package, alongside the transmitter's idle constant.
REQ-027 One sub-module is natural: com_detect (combinational equality of sr_next with COM_SYMBOL); the state machine and counters SHALL remain in serial_a_paralelo.

Verification
REQ-028 Scenario 1: reset, then 4 x 8'hBC MSB first with arbitrary bit phase -> active rises at the edge sampling the LSB of the 4th aligned BC; out_valid = 0.
REQ-029 Scenario 2: after lock, send 8'h5A then 8'hBC -> out = 8'h5A with out_valid = 1 for 8 cycles, then out_valid = 0 with out still 8'h5A; byte_strobe pulses once per byte.
REQ-030 Scenario 3: send 2 x BC, then 8'h00 -> return to SEARCH; active stays 0; then 4 x BC -> lock.
REQ-031 Scenario 4: loopback from paralelo_a_serial sharing clk32f, sending bytes 8'h01, 8'hFF, 8'h80 with in_valid = 1 after idle BCs -> the same bytes appear in order on out with out_valid = 1.
REQ-032 Scenario 5: assert reset for 1 cycle mid-byte while LOCKED -> all outputs are 0 immediately; lock is regained only after 4 fresh aligned BCs.
REQ-033 Scenario 6: 3 random bits, then a bit slip (one bit dropped) inside the BC preamble -> lock is still achieved on the new phase, and the first data byte is decoded correctly.
